csr_commit_ctrl: RTL

CSR_COMMIT_CTRL -- requirements
Module: csr_commit_ctrl

---
 rtl/ariane_pkg.sv | 11 +
 rtl/config_pkg.sv | 10 +
 rtl/csr_commit_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared core definitions: CSR operation encoding used by the commit path.
package ariane_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_t;

endpackage

// File: rtl/config_pkg.sv
// CPU configuration stand-in: only the fields this slice consumes.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd32};

endpackage

// File: rtl/csr_commit_ctrl.sv
// Sequences a committed CSR op as read-modify-write against the CSR file
// and returns the old value to the commit stage.
module csr_commit_ctrl
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    commit_valid_i,
    output logic                    commit_ready_o,
    input  logic [1:0]              csr_op_i,
    input  logic [11:0]             csr_addr_i,
    input  logic [CVA6Cfg.XLEN-1:0] csr_wdata_i,
    input  logic                    suppress_wr_i,
    output logic                    csr_req_o,
    output logic                    csr_we_o,
    output logic [11:0]             csr_addr_o,
    output logic [CVA6Cfg.XLEN-1:0] csr_wdata_o,
    input  logic                    csr_gnt_i,
    input  logic [CVA6Cfg.XLEN-1:0] csr_rdata_i,
    input  logic                    csr_ex_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [CVA6Cfg.XLEN-1:0] rsp_rdata_o,
    output logic                    rsp_ex_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]              state_q, state_d;
    csr_op_t                 op_q, op_d;
    logic [11:0]             addr_q, addr_d;
    logic [CVA6Cfg.XLEN-1:0] wdata_q, wdata_d;
    logic [CVA6Cfg.XLEN-1:0] old_q, old_d;
    logic                    supp_q, supp_d;
    logic                    ex_q, ex_d;
    logic                    drop_q, drop_d;
    logic [CVA6Cfg.XLEN-1:0] new_val;
    logic                    skip_write;

    always_comb begin
        new_val = wdata_q;
        case (op_q)
            CSR_SET:   new_val = old_q | wdata_q;
            CSR_CLEAR: new_val = old_q & ~wdata_q;
            default:   new_val = wdata_q;
        endcase
    end

    assign skip_write = (op_q == CSR_READ) ||
                        (supp_q && ((op_q == CSR_SET) || (op_q == CSR_CLEAR)));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        supp_d  = supp_q;
        ex_d    = ex_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (commit_valid_i && !flush_i) begin
                    op_d    = csr_op_t'(csr_op_i);
                    addr_d  = csr_addr_i;
                    wdata_d = csr_wdata_i;
                    supp_d  = suppress_wr_i;
                    ex_d    = 1'b0;
                    drop_d  = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (csr_gnt_i) begin
                    old_d = csr_rdata_i;
                    if (csr_ex_i) begin
                        ex_d    = 1'b1;
                        state_d = RESP;
                    end else if (skip_write) begin
                        state_d = RESP;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // A flush cannot abort an issued write; remember it and drop the response.
                if (flush_i) drop_d = 1'b1;
                if (csr_gnt_i) begin
                    if (csr_ex_i) ex_d = 1'b1;
                    if (drop_q || flush_i) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            default: begin
                if (flush_i || rsp_ready_i) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= CSR_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            supp_q  <= 1'b0;
            ex_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            supp_q  <= supp_d;
            ex_q    <= ex_d;
            drop_q  <= drop_d;
        end
    end

    assign commit_ready_o = (state_q == IDLE);
    assign csr_req_o      = (state_q == READ) || (state_q == WRITE);
    assign csr_we_o       = (state_q == WRITE);
    assign csr_addr_o     = addr_q;
    assign csr_wdata_o    = new_val;
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_rdata_o    = old_q;
    assign rsp_ex_o       = ex_q;

endmodule
